// File: rtl/sfr_int_ctrl.sv
// SFR-mapped interrupt controller: per-source trigger detection, lowest-index arbitration and a
// single-level request/service handshake. Define INT_SYNC_EN for a two-flop input synchronizer.
module sfr_int_ctrl #(
    parameter int unsigned NSRC = 16
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic [NSRC-1:0]       int_src,
    input  logic [7:0]            icr,
    input  logic [NSRC-1:0]       int_mask,
    input  logic [2*NSRC-1:0]     trig_cfg,
    input  logic                  irq_ack,
    input  logic                  irq_done,
    output logic                  irq,
    output logic [3:0]            irq_vector,
    output logic [31:0]           status
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StReq     = 2'd1;
    localparam logic [1:0] StService = 2'd2;

    logic [NSRC-1:0] in_stage;
    logic [NSRC-1:0] s_q, p_q;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [1:0]      state_q, state_d;
    logic            irq_q, irq_d;
    logic [3:0]      irq_vector_q, irq_vector_d;
    logic [NSRC-1:0] qual;
    logic [3:0]      first_idx;
    logic            ack_fire;
    logic            unused_icr;

    assign unused_icr = ^icr[7:1];

`ifdef INT_SYNC_EN
    logic [NSRC-1:0] sync1_q, sync2_q;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= int_src;
            sync2_q <= sync1_q;
        end
    end

    assign in_stage = sync2_q;
`else
    logic [NSRC-1:0] in_q;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            in_q <= '0;
        end else begin
            in_q <= int_src;
        end
    end

    assign in_stage = in_q;
`endif

    // s is the sampled source, p its previous value; both start at zero after reset
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            s_q <= '0;
            p_q <= '0;
        end else begin
            s_q <= in_stage;
            p_q <= s_q;
        end
    end

    assign ack_fire = (state_q == StReq) && irq_ack;

    // Edge modes hold until acknowledged; a coincident new edge wins over the clear
    always_comb begin
        logic [1:0] mode;
        logic       clr;
        pending_d = '0;
        for (int i = 0; i < int'(NSRC); i++) begin
            mode = trig_cfg[2*i +: 2];
            clr  = ack_fire && (irq_vector_q == 4'(i));
            case (mode)
                2'b00:   pending_d[i] = s_q[i];
                2'b01:   pending_d[i] = ~s_q[i];
                2'b10:   pending_d[i] = (s_q[i] & ~p_q[i]) | (pending_q[i] & ~clr);
                default: pending_d[i] = (~s_q[i] & p_q[i]) | (pending_q[i] & ~clr);
            endcase
        end
    end

    assign qual = pending_q & int_mask;

    always_comb begin
        first_idx = 4'd0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (qual[i]) begin
                first_idx = 4'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        irq_d        = irq_q;
        irq_vector_d = irq_vector_q;
        case (state_q)
            StIdle: begin
                if (icr[0] && (|qual)) begin
                    irq_vector_d = first_idx;
                    irq_d        = 1'b1;
                    state_d      = StReq;
                end
            end
            StReq: begin
                if (irq_ack) begin
                    irq_d   = 1'b0;
                    state_d = StService;
                end
            end
            StService: begin
                if (irq_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                irq_d   = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            pending_q    <= '0;
            state_q      <= StIdle;
            irq_q        <= 1'b0;
            irq_vector_q <= 4'd0;
        end else begin
            pending_q    <= pending_d;
            state_q      <= state_d;
            irq_q        <= irq_d;
            irq_vector_q <= irq_vector_d;
        end
    end

    assign irq        = irq_q;
    assign irq_vector = irq_vector_q;
    assign status     = {10'd0, (state_q == StService), irq_q, irq_vector_q, pending_q};

endmodule

// File: tb/tb_sfr_int_ctrl.sv
// Self-checking bench for sfr_int_ctrl: steady-state vector table, timed corner sequences and a
// randomized run against a history-based reference model. Honours INT_SYNC_EN.
module tb_sfr_int_ctrl;

`ifdef INT_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic [15:0] int_src = '0;
    logic [7:0]  icr = '0;
    logic [15:0] int_mask = '0;
    logic [31:0] trig_cfg = '0;
    logic        irq_ack = 1'b0;
    logic        irq_done = 1'b0;
    logic        irq;
    logic [3:0]  irq_vector;
    logic [31:0] status;

    int n_chk = 0;
    int n_bad = 0;

    sfr_int_ctrl dut (
        .clock      (clock),
        .nreset     (nreset),
        .int_src    (int_src),
        .icr        (icr),
        .int_mask   (int_mask),
        .trig_cfg   (trig_cfg),
        .irq_ack    (irq_ack),
        .irq_done   (irq_done),
        .irq        (irq),
        .irq_vector (irq_vector),
        .status     (status)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [15:0] src;
        logic [7:0]  icr;
        logic [15:0] mask;
        logic [31:0] trig;
        logic        ack;
        logic        done;
        int          waitc;
        logic        e_irq;
        logic [3:0]  e_vec;
        logic [15:0] e_pend;
        logic        e_svc;
    } vec_t;

    vec_t tbl[22];

    // Reference model: input history instead of a flop pipeline
    logic [15:0] m_hist[4];
    logic [15:0] m_pend;
    int          m_state;  // 0 idle, 1 requesting, 2 in service
    logic        m_irq;
    int          m_vec;

    function automatic logic [39:0] expw(logic e_irq, logic [3:0] e_vec, logic [15:0] e_pend,
                                         logic e_svc);
        return {e_irq, e_vec, 10'd0, e_svc, e_irq, e_vec, e_pend};
    endfunction

    task automatic chk(string name, logic [39:0] exp);
        logic [39:0] act;
        act = {irq, irq_vector, status};
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got irq=%b vec=%h status=%h, expected irq=%b vec=%h status=%h",
                     name, act[39], act[38:35], act[31:0], exp[39], exp[38:35], exp[31:0]);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_irq(string name, int max);
        for (int c = 0; c < max && irq !== 1'b1; c++) step();
        n_chk++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: irq=%b after %0d cycles, expected 1", name, irq, max);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_hist[i] = '0;
        m_pend  = '0;
        m_state = 0;
        m_irq   = 1'b0;
        m_vec   = 0;
    endtask

    task automatic do_reset();
        #1;
        nreset   = 1'b0;
        int_src  = '0;
        icr      = '0;
        int_mask = '0;
        trig_cfg = '0;
        irq_ack  = 1'b0;
        irq_done = 1'b0;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        nreset = 1'b1;
    endtask

    // One clock edge of the reference model, using the inputs held before that edge
    task automatic model_step();
        logic [15:0] s, p, np, q;
        int          lowest;
        s = m_hist[D];
        p = m_hist[D+1];
        for (int i = 0; i < 16; i++) begin
            logic clr;
            clr = (m_state == 1) && irq_ack && (m_vec == i);
            case (trig_cfg[2*i +: 2])
                2'b00:   np[i] = s[i];
                2'b01:   np[i] = !s[i];
                2'b10:   np[i] = (s[i] && !p[i]) || (m_pend[i] && !clr);
                default: np[i] = (!s[i] && p[i]) || (m_pend[i] && !clr);
            endcase
        end
        q = m_pend & int_mask;
        lowest = -1;
        for (int i = 15; i >= 0; i--) if (q[i]) lowest = i;
        if (m_state == 0) begin
            if (icr[0] && lowest >= 0) begin
                m_vec   = lowest;
                m_irq   = 1'b1;
                m_state = 1;
            end
        end else if (m_state == 1) begin
            if (irq_ack) begin
                m_irq   = 1'b0;
                m_state = 2;
            end
        end else if (irq_done) begin
            m_state = 0;
        end
        m_pend = np;
        for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = int_src;
    endtask

    initial begin
        // src, icr, mask, trig, ack, done, wait, irq, vec, pending, in-service
        tbl[0]  = '{16'h0000, 8'h01, 16'hFFFF, 32'h0, 1'b0, 1'b0, 6, 1'b0, 4'h0, 16'h0000, 1'b0};
        tbl[1]  = '{16'h0020, 8'h01, 16'hFFFF, 32'h0, 1'b0, 1'b0, 6, 1'b1, 4'h5, 16'h0020, 1'b0};
        tbl[2]  = '{16'h0020, 8'h01, 16'hFFFF, 32'h0, 1'b1, 1'b0, 3, 1'b0, 4'h5, 16'h0020, 1'b1};
        tbl[3]  = '{16'h0020, 8'h01, 16'hFFFF, 32'h0, 1'b0, 1'b1, 3, 1'b1, 4'h5, 16'h0020, 1'b0};
        tbl[4]  = '{16'h0000, 8'h01, 16'hFFFF, 32'h0, 1'b1, 1'b0, 6, 1'b0, 4'h5, 16'h0000, 1'b1};
        tbl[5]  = '{16'h0000, 8'h01, 16'hFFFF, 32'h0, 1'b0, 1'b1, 6, 1'b0, 4'h5, 16'h0000, 1'b0};
        tbl[6]  = '{16'h8001, 8'h01, 16'h8000, 32'h0, 1'b0, 1'b0, 6, 1'b1, 4'hF, 16'h8001, 1'b0};
        tbl[7]  = '{16'h8001, 8'h01, 16'h0000, 32'h0, 1'b0, 1'b0, 4, 1'b1, 4'hF, 16'h8001, 1'b0};
        tbl[8]  = '{16'h8001, 8'h00, 16'h0000, 32'h0, 1'b0, 1'b0, 4, 1'b1, 4'hF, 16'h8001, 1'b0};
        tbl[9]  = '{16'h8001, 8'h00, 16'h0000, 32'h0, 1'b1, 1'b0, 3, 1'b0, 4'hF, 16'h8001, 1'b1};
        tbl[10] = '{16'h8001, 8'h00, 16'h0000, 32'h0, 1'b0, 1'b1, 4, 1'b0, 4'hF, 16'h8001, 1'b0};
        tbl[11] = '{16'h8001, 8'h01, 16'h0001, 32'h0, 1'b0, 1'b0, 4, 1'b1, 4'h0, 16'h8001, 1'b0};
        tbl[12] = '{16'h8001, 8'h01, 16'h0001, 32'h0, 1'b0, 1'b1, 3, 1'b1, 4'h0, 16'h8001, 1'b0};
        tbl[13] = '{16'h8001, 8'h01, 16'h0001, 32'h0, 1'b1, 1'b0, 3, 1'b0, 4'h0, 16'h8001, 1'b1};
        tbl[14] = '{16'h8001, 8'h01, 16'h0001, 32'h0, 1'b1, 1'b0, 3, 1'b0, 4'h0, 16'h8001, 1'b1};
        tbl[15] = '{16'h0000, 8'h01, 16'h0000, 32'h0, 1'b0, 1'b1, 6, 1'b0, 4'h0, 16'h0000, 1'b0};
        tbl[16] = '{16'hFFFE, 8'h01, 16'h0001, 32'h55555555, 1'b0, 1'b0, 6,
                    1'b1, 4'h0, 16'h0001, 1'b0};
        tbl[17] = '{16'hFFFE, 8'h01, 16'h0001, 32'h55555555, 1'b1, 1'b0, 3,
                    1'b0, 4'h0, 16'h0001, 1'b1};
        tbl[18] = '{16'h0000, 8'h01, 16'h0000, 32'h0, 1'b0, 1'b1, 6, 1'b0, 4'h0, 16'h0000, 1'b0};
        tbl[19] = '{16'h0010, 8'h01, 16'h0010, 32'hAAAAAAAA, 1'b0, 1'b0, 6,
                    1'b1, 4'h4, 16'h0010, 1'b0};
        tbl[20] = '{16'h0000, 8'h01, 16'h0010, 32'hAAAAAAAA, 1'b1, 1'b0, 6,
                    1'b0, 4'h4, 16'h0000, 1'b1};
        tbl[21] = '{16'h0000, 8'h01, 16'h0010, 32'hAAAAAAAA, 1'b0, 1'b1, 4,
                    1'b0, 4'h4, 16'h0000, 1'b0};

        do_reset();
        chk("reset_state", expw(1'b0, 4'h0, 16'h0000, 1'b0));

        for (int i = 0; i < 22; i++) begin
            int_src  = tbl[i].src;
            icr      = tbl[i].icr;
            int_mask = tbl[i].mask;
            trig_cfg = tbl[i].trig;
            irq_ack  = tbl[i].ack;
            irq_done = tbl[i].done;
            step();
            irq_ack  = 1'b0;
            irq_done = 1'b0;
            repeat (tbl[i].waitc - 1) step();
            chk($sformatf("table_%0d", i),
                expw(tbl[i].e_irq, tbl[i].e_vec, tbl[i].e_pend, tbl[i].e_svc));
        end

        // Source 3 rising edge: exact latency, acknowledge clears, done returns to idle
        do_reset();
        trig_cfg = 32'h0000_0080;
        int_mask = 16'h0008;
        icr      = 8'h01;
        step();
        step();
        int_src = 16'h0008;
        step();
        step();
        int_src = 16'h0000;
        repeat (D) step();
        chk("edge_pending_before_irq", expw(1'b0, 4'h0, 16'h0008, 1'b0));
        step();
        chk("edge_irq_latency", expw(1'b1, 4'h3, 16'h0008, 1'b0));
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("edge_ack_service", expw(1'b0, 4'h3, 16'h0000, 1'b1));
        irq_done = 1'b1;
        step();
        irq_done = 1'b0;
        chk("edge_done_idle", expw(1'b0, 4'h3, 16'h0000, 1'b0));
        repeat (3) step();
        chk("edge_idle_stays", expw(1'b0, 4'h3, 16'h0000, 1'b0));

        // New edge detected on the same cycle as the acknowledge keeps the bit pending
        int_src = 16'h0008;
        wait_irq("coincide_first_irq", 10);
        int_src = 16'h0000;
        repeat (D + 2) step();
        int_src = 16'h0008;
        repeat (D + 1) step();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("coincide_set_wins", expw(1'b0, 4'h3, 16'h0008, 1'b1));
        irq_done = 1'b1;
        step();
        irq_done = 1'b0;
        step();
        chk("coincide_reassert", expw(1'b1, 4'h3, 16'h0008, 1'b0));

        // Simultaneous edges on 2 and 7: lowest index first, then the other
        do_reset();
        trig_cfg = 32'h0000_8020;
        int_mask = 16'h0084;
        icr      = 8'h01;
        step();
        int_src = 16'h0084;
        step();
        step();
        int_src = 16'h0000;
        wait_irq("prio_first_irq", 10);
        chk("prio_vec2", expw(1'b1, 4'h2, 16'h0084, 1'b0));
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("prio_ack2", expw(1'b0, 4'h2, 16'h0080, 1'b1));
        irq_done = 1'b1;
        step();
        irq_done = 1'b0;
        wait_irq("prio_second_irq", 5);
        chk("prio_vec7", expw(1'b1, 4'h7, 16'h0080, 1'b0));
        irq_ack = 1'b1;
        step();
        irq_ack  = 1'b0;
        irq_done = 1'b1;
        step();
        irq_done = 1'b0;
        step();
        chk("prio_all_served", expw(1'b0, 4'h7, 16'h0000, 1'b0));

        // Global enable gates arbitration; asynchronous reset in the request state
        do_reset();
        int_mask = 16'h0002;
        int_src  = 16'h0002;
        repeat (6) step();
        chk("gen_disabled", expw(1'b0, 4'h0, 16'h0002, 1'b0));
        icr = 8'h01;
        step();
        chk("gen_enabled", expw(1'b1, 4'h1, 16'h0002, 1'b0));
        #2;
        nreset = 1'b0;
        #1;
        chk("async_reset_in_req", expw(1'b0, 4'h0, 16'h0000, 1'b0));
        int_src = 16'h0000;
        @(posedge clock);
        @(posedge clock);
        #1;
        nreset = 1'b1;
        repeat (8) step();
        chk("no_irq_after_reset", expw(1'b0, 4'h0, 16'h0000, 1'b0));

        // Randomized run against the reference model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                trig_cfg = $urandom;
                int_mask = 16'($urandom);
            end
            if ($urandom_range(0, 31) == 0) int_mask = 16'($urandom);
            icr      = {7'($urandom), ($urandom_range(0, 7) != 0)};
            int_src  = int_src ^ 16'($urandom & $urandom & $urandom);
            irq_ack  = ($urandom_range(0, 3) == 0);
            irq_done = ($urandom_range(0, 3) == 0);
            step();
            model_step();
            chk($sformatf("random_%0d", c),
                expw(m_irq, 4'(m_vec), m_pend, (m_state == 2)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/sfr_int_ctrl.md
SFR_INT_CTRL -- requirements
Module: sfr_int_ctrl

Interface
REQ-001 Parameter NSRC, default 16, number of interrupt sources; fixed at 16 in this revision.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 nreset  input  1  reset, asynchronous assert, active-low.
REQ-004 int_src  input  16  raw peripheral interrupt lines; may be asynchronous to clock.
REQ-005 icr  input  8  controller control byte from SFR output bus; bit0 = global enable, bits7:1 ignored.
REQ-006 int_mask  input  16  per-source enable from SFR output bus; 1 = enabled.
REQ-007 trig_cfg  input  32  two bits per source (bits 2i+1:2i): 00 level-high, 01 level-low, 10 rising edge, 11 falling edge.
REQ-008 irq_ack  input  1  CPU accepts current request; one-cycle pulse.
REQ-009 irq_done  input  1  CPU finished the handler (return-from-interrupt); one-cycle pulse.
REQ-010 irq  output  1  interrupt request to CPU, registered.
REQ-011 irq_vector  output  4  index of requested/serviced source, registered.
REQ-012 status  output  32  to SFR input bus: [15:0] pending, [19:16] irq_vector, [20] irq, [21] in-service, [31:22] zero.

Function
REQ-013 Each source is sampled through an input stage; the sampled value s[i] and its one-cycle-delayed copy p[i] are used for detection.
REQ-014 Edge modes: pending[i] sets the cycle after s[i]/p[i] show the configured edge; stays set until cleared by acknowledge.
REQ-015 Level modes: pending[i] is recomputed every cycle from s[i] and the configured polarity; acknowledge does not clear it.
REQ-016 Set and clear of the same edge-mode pending bit in the same cycle: set wins.
REQ-017 FSM states IDLE, REQ, SERVICE; reset state IDLE.
REQ-018 IDLE: if icr[0]=1 and (pending & int_mask) != 0, latch lowest-index qualifying source into irq_vector, assert irq, go to REQ.
REQ-019 REQ: irq held at 1; on irq_ack, clear pending[irq_vector] if edge mode, deassert irq, go to SERVICE; mask/enable changes in REQ do not withdraw irq.
REQ-020 SERVICE: irq=0, irq_vector held, status[21]=1; on irq_done go to IDLE; no nesting.
REQ-021 irq_ack outside REQ and irq_done outside SERVICE are ignored.
REQ-022 Latency (no macro): int_src edge settling before clock edge k gives pending set after edge k+2 and irq=1 after edge k+3.
REQ-023 Back-to-back: re-arbitration occurs in the first IDLE cycle after irq_done; irq may reassert one cycle after returning to IDLE.

Reset
REQ-024 nreset low asynchronously clears pending, sample registers, irq, irq_vector, and status, and forces IDLE, including mid-REQ or mid-SERVICE.
REQ-025 After release, no edge is detected from pre-reset history; p and s start at 0.

Configuration
REQ-026 INT_SYNC_EN defined: input stage is a two-flop synchronizer per source; all latencies in REQ-022 increase by one cycle (irq after edge k+4).
REQ-027 INT_SYNC_EN undefined: input stage is a single register per source; latency as REQ-022.

Verification
REQ-028 Source 3 rising-edge, mask=0x0008, icr=0x01; pulse int_src[3] -> irq=1 with vector=3 at k+3; ack -> pending[3]=0, status[21]=1; done -> IDLE.
REQ-029 Sources 2 and 7 rising edge in the same cycle, both enabled -> vector=2 first; after ack+done -> vector=7 served next.
REQ-030 Source 5 level-high held high, ack+done -> irq reasserts with vector 5 until int_src[5]=0.
REQ-031 icr=0x00 with pending[1]=1 -> irq stays 0; set icr=0x01 -> irq=1 next cycle, vector=1.
REQ-032 Assert nreset low while in REQ -> irq=0, pending=0, status=0 immediately, without waiting for a clock edge; after release no spurious irq.
REQ-033 With INT_SYNC_EN, repeat REQ-028 -> irq at k+4; an edge on source 3 coincident with ack -> pending[3] remains 1.
